// File: rtl/decy_batch_ctrl_if.sv
// Pixel stream bundle for the decryption controller.
// s_* is the encrypted input stream and m_* is the decrypted output stream.
interface decy_batch_ctrl_if;
  localparam int unsigned PIX_W = 24;

  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;

  // Controller side: consumes the cipher stream and produces the plain stream
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  // Pixel source / sink side
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/decy_batch_ctrl.sv
// Sequencing controller for the 24-bit pixel decryption datapath: per-image keystream
// re-seed, one keystream step per accepted pixel, registered output stage and image count.
module decy_batch_ctrl #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned BATCH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_pix,
  input  logic               abort,
  decy_batch_ctrl_if.slave   pix,
  output logic               dp_reseed,
  output logic               dp_step,
  output logic [23:0]        dp_cipher,
  input  logic [23:0]        dp_plain,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               err_zero,
  output logic [BATCH_W-1:0] img_cnt
);

  localparam int unsigned PIX_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] remaining;
  logic             m_valid_q;
  logic             m_last_q;
  logic [PIX_W-1:0] m_data_q;

  logic active;
  logic kill;
  logic out_hs;
  logic s_rdy;
  logic accept;
  logic final_hs;
  logic start_ok;
  logic start_zero;

  assign active = (state != IDLE);
  assign kill   = abort & active;
  assign out_hs = m_valid_q & pix.m_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake decode; abort overrides everything outside IDLE
  always_comb begin
    state_nxt  = state;
    s_rdy      = 1'b0;
    accept     = 1'b0;
    final_hs   = 1'b0;
    start_ok   = 1'b0;
    start_zero = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (num_pix != '0) begin
            start_ok  = 1'b1;
            state_nxt = SEED;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      SEED: begin
        state_nxt = RUN;
      end
      RUN: begin
        s_rdy  = (remaining != '0) && (!m_valid_q || pix.m_ready) && !abort;
        accept = pix.s_valid && s_rdy;
        if (accept && (remaining == CNT_W'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        final_hs = out_hs & m_last_q;
        if (final_hs) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (kill) begin
      state_nxt = IDLE;
      final_hs  = 1'b0;
    end
  end

  // Output register, pixel budget and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      err_zero  <= 1'b0;
      img_cnt   <= '0;
    end else begin
      done     <= final_hs;
      aborted  <= kill;
      err_zero <= start_zero;
      if (final_hs) begin
        img_cnt <= img_cnt + BATCH_W'(1);
      end
      if (kill) begin
        remaining <= '0;
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end else begin
        if (start_ok) begin
          remaining <= num_pix;
        end
        if (accept) begin
          m_data_q  <= dp_plain;
          m_valid_q <= 1'b1;
          m_last_q  <= (remaining == CNT_W'(1));
          remaining <= remaining - CNT_W'(1);
        end else if (out_hs) begin
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      end
    end
  end

  // Keystream advances only on an accepted pixel, so stalls never skew key alignment
  assign dp_step     = accept;
  assign dp_cipher   = pix.s_data;
  assign dp_reseed   = rst | (state == SEED);
  assign busy        = active;

  assign pix.s_ready = s_rdy;
  assign pix.m_valid = m_valid_q;
  assign pix.m_data  = m_data_q;
  assign pix.m_last  = m_last_q;

endmodule

// File: doc/decy_batch_ctrl.md
# decy_batch_ctrl

Sequencing controller for the 24-bit pixel decryption datapath (`decy_master`: three per-channel LFSR keystreams feeding the XOR/PPHCG/Feynman/Peres network). It re-seeds the keystreams at the start of every image, and advances them by exactly one step per accepted pixel so key alignment survives stalls on either side. It moves pixels between a valid/ready input stream and a registered valid/ready output stream, and counts images across a batch.

## Interface
Parameters:
- `CNT_W`, 20: width of per-image pixel count; max image = 2^CNT_W−1 pixels
- `BATCH_W`, 8: width of completed-image counter

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: begin one image; sampled only in IDLE
- `num_pix` in CNT_W: pixel count of the image, captured when `start` is accepted
- `abort` in 1: terminate current image
- `s_valid` in 1, `s_ready` out 1, `s_data` in 24: encrypted pixel stream, {B,G,R}
- `m_valid` out 1, `m_ready` in 1, `m_data` out 24, `m_last` out 1: decrypted pixel stream
- `dp_reseed` out 1: drives datapath LFSR reset; loads seed 8'h01 in all three channels
- `dp_step` out 1: datapath keystream advance enable (LFSRs shift only when 1)
- `dp_cipher` out 24: pixel presented to the datapath
- `dp_plain` in 24: datapath decrypted result (combinational from `dp_cipher` and LFSR state)
- `busy` out 1, `done` out 1 (pulse), `aborted` out 1 (pulse), `err_zero` out 1 (pulse), `img_cnt` out BATCH_W

## Operation
- States: IDLE, SEED, RUN, DRAIN.
- IDLE: `start`=1 with `num_pix`≠0 → capture `remaining`=`num_pix`, go SEED. `start` with `num_pix`=0 → `err_zero` pulse, stay IDLE, no reseed.
- SEED: `dp_reseed`=1 for exactly one cycle → RUN.
- RUN: `s_ready` = (`remaining`≠0) & (!`m_valid` | `m_ready`). Accept = `s_valid` & `s_ready`.
- On accept: `dp_step`=1, `m_data`<=`dp_plain`, `m_valid`<=1, `m_last`<=(`remaining`==1), `remaining`−=1.
- Pixel k of an image (k from 0) is decrypted with the LFSR state after exactly k steps from seed.
- After the last accept → DRAIN. DRAIN: when `m_valid`&`m_ready`&`m_last` → `done` pulse next cycle, `img_cnt`+=1, go IDLE.
- `img_cnt` wraps 2^BATCH_W−1 → 0 and is cleared only by `rst`.
- `dp_cipher` = `s_data` (combinational pass-through); `dp_step` = accept (combinational).
- `dp_reseed` = `rst` | (state==SEED). Reset therefore also re-seeds the datapath.
- `abort`, in any non-IDLE state: next cycle IDLE, `m_valid`=0, `m_last`=0, `remaining`=0, `aborted` pulse. No `done`; `img_cnt` unchanged. `s_ready`=0 in the abort cycle. In IDLE, `abort` is ignored.
- `abort` and `start` in the same IDLE cycle: abort wins, and `start` is dropped.
- `start` outside IDLE is ignored.
- `busy` = state≠IDLE.

## Timing
- Reset values: state IDLE, `s_ready`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `dp_step`=0, `dp_reseed`=1 while `rst` is high, `busy`=0, `done`=0, `aborted`=0, `err_zero`=0, `img_cnt`=0, `remaining`=0.
- `start` accepted at edge of cycle 0 → SEED in cycle 1 (`dp_reseed`=1) → RUN in cycle 2, when `s_ready` can first be 1.
- Latency: accept in cycle t → `m_valid`=1 with data in cycle t+1.
- Throughput: 1 pixel/cycle while `m_ready`=1.
- `m_valid`/`m_data`/`m_last` hold stable until handshake. `s_ready` is 0 while the output register is full and `m_ready`=0, so no pixel is accepted and no LFSR step occurs.
- Final output handshake in cycle t → `done`=1 and `busy`=0 in cycle t+1, `img_cnt` updated in cycle t+1. `start` is accepted from cycle t+1.
- `rst` mid-image: all state cleared at next edge, with no `done`/`aborted` pulse.

## Test plan
- Single image: `num_pix`=4, four `s_data` values, `m_ready`=1 → four outputs matching the golden `decy_master` model from seed 8'h01. `m_last` on 4th only; `done` 1 cycle after 4th handshake; `img_cnt`=1.
- Backpressure: `num_pix`=8, `m_ready` toggled 1/0 every cycle plus random `s_valid` gaps → outputs identical to the unstalled run. Exactly 8 `dp_step` pulses.
- Batch re-seed: two consecutive images, each `num_pix`=3 with identical cipher pixels → identical output triples; `dp_reseed` pulses once per image; `img_cnt`=2.
- Abort: `num_pix`=10, `abort` after 5 accepts → `aborted` pulse, `m_valid`=0, `img_cnt` unchanged. The next image with `num_pix`=2 decrypts from the seed.
- Corners: `start` with `num_pix`=0 → `err_zero` pulse, `busy` stays 0. `start`+`abort` in the same cycle → stays IDLE. `img_cnt` at 255 + one image → 0.
- `rst` asserted mid-image after 3 accepts → all outputs at reset values. A subsequent image of 2 pixels matches the golden model from the seed.
